// File: rtl/dc_pkg.sv
// Shared types and constants for the dc_scan one-hot decoder/scanner.
// Holds the FSM state enum and the reference one-hot helper.
package dc_pkg;

    localparam int DEF_AW    = 3;
    localparam int DEF_DWELL = 4;
    localparam int DEF_BLANK = 1;
    localparam int MAX_AW    = 8;
    localparam int MAX_W     = 1 << MAX_AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Bits at or above 2**aw are always zero.
    function automatic logic [MAX_W-1:0] onehot(
        input logic [MAX_AW-1:0] addr,
        input int                aw
    );
        logic [MAX_W-1:0] r;
        r = '0;
        if (int'(addr) < (1 << aw)) begin
            r[addr] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dc_onehot.sv
// Combinational AW -> 2**AW one-hot decoder with enable.
// Output is active-high; polarity is applied by the caller.
module dc_onehot
    import dc_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0]      addr,
    input  logic               en,
    output logic [(1<<AW)-1:0] hot
);

    localparam int N = 1 << AW;

    assign hot = en ? N'(onehot(MAX_AW'(addr), AW)) : '0;

endmodule

// File: rtl/dc_scan.sv
// Registered one-hot decoder with a built-in scan sequencer that
// walks the selects with programmable dwell and blanking.
module dc_scan
    import dc_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DWELL   = DEF_DWELL,
    parameter int BLANK   = DEF_BLANK,
    parameter int ACT_LOW = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               mode,
    input  logic [AW-1:0]      a,
    input  logic               ld,
    output logic [(1<<AW)-1:0] d,
    output logic [AW-1:0]      idx,
    output logic               wrap,
    output logic               busy
);

    localparam int N   = 1 << AW;
    localparam int PER = BLANK + DWELL;
    localparam int PW  = $clog2(PER + 1);

    localparam logic [PW-1:0] LAST  = PW'(PER - 1);
    localparam logic [AW-1:0] TOP   = '1;
    localparam logic [N-1:0]  INACT = {N{ACT_LOW != 0}};

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic [AW-1:0] idx_nxt;
    logic [AW-1:0] dec_addr;
    logic          dec_en;
    logic          in_blank;
    logic          wrap_nxt;
    logic [N-1:0]  hot;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        phase_nxt = '0;
        if (!ena) begin
            state_nxt = IDLE;
        end else if (!mode) begin
            state_nxt = DIRECT;
        end else if (state != SCAN) begin
            state_nxt = SCAN;
            idx_nxt   = a;
        end else if (ld) begin
            idx_nxt   = a;
        end else if (phase == LAST) begin
            idx_nxt   = idx + AW'(1);
        end else begin
            phase_nxt = phase + PW'(1);
        end
    end

    // Blanking occupies the first BLANK phases of every slot.
    if (BLANK == 0) begin : g_noblank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = phase_nxt < PW'(BLANK);
    end

    always_comb begin
        dec_en   = 1'b0;
        dec_addr = idx_nxt;
        wrap_nxt = 1'b0;
        if (state_nxt == DIRECT) begin
            dec_en   = 1'b1;
            dec_addr = a;
        end else if (state_nxt == SCAN) begin
            dec_en   = !in_blank;
            wrap_nxt = (phase_nxt == LAST) && (idx_nxt == TOP);
        end
    end

    dc_onehot #(
        .AW (AW)
    ) u_dec (
        .addr (dec_addr),
        .en   (dec_en),
        .hot  (hot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            phase <= '0;
            d     <= INACT;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            phase <= phase_nxt;
            d     <= hot ^ INACT;
            wrap  <= wrap_nxt;
        end
    end

    assign busy = (state == SCAN);

endmodule

// File: tb/tb_dc_scan.sv
// Scoreboard bench for dc_scan: default instance plus a
// BLANK=0 / active-low variant sharing the same stimulus.
module tb_dc_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       mode = 1'b0;
    logic       ld = 1'b0;
    logic [2:0] a = '0;

    logic [7:0] d0, d1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1, busy0, busy1;

    typedef struct {
        logic [7:0] d;
        logic [2:0] idx;
        logic       wrap;
        logic       busy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    dc_scan u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
        .a(a), .ld(ld), .d(d0), .idx(idx0),
        .wrap(wrap0), .busy(busy0)
    );

    dc_scan #(.BLANK(0), .ACT_LOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
        .a(a), .ld(ld), .d(d1), .idx(idx1),
        .wrap(wrap1), .busy(busy1)
    );

    function automatic exp_t mk(logic [7:0] dd, logic [2:0] ii,
                                logic ww, logic bb);
        exp_t r;
        r.d = dd; r.idx = ii; r.wrap = ww; r.busy = bb;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; ena = 1; mode = 1; a = 3'd6;
        for (int i = 0; i < 2; i++) begin
            q.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0));
            tick();
            e = q.pop_front(); total++;
            if (d0 !== e.d || idx0 !== e.idx || wrap0 !== e.wrap || busy0 !== e.busy) begin
                bad++;
                $display("FAIL reset[%0d]: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                         i, d0, idx0, wrap0, busy0, e.d, e.idx, e.wrap, e.busy);
            end
        end
        rst_n = 1;
        q.push_back(mk(8'h00, 3'd6, 1'b0, 1'b1));
        q.push_back(mk(8'h40, 3'd6, 1'b0, 1'b1));
        for (int i = 0; i < 2; i++) begin
            tick();
            e = q.pop_front(); total++;
            if (d0 !== e.d || idx0 !== e.idx || wrap0 !== e.wrap || busy0 !== e.busy) begin
                bad++;
                $display("FAIL reset_release[%0d]: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                         i, d0, idx0, wrap0, busy0, e.d, e.idx, e.wrap, e.busy);
            end
        end
    endtask

    task automatic test_direct();
        logic [7:0] one;
        one = 8'h01;
        ena = 1; mode = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                a = 3'(i);
                q.push_back(mk(one << i, 3'd6, 1'b0, 1'b0));
            end else begin
                ena = 0;
                q.push_back(mk(8'h00, 3'd6, 1'b0, 1'b0));
            end
            tick();
            e = q.pop_front(); total++;
            if (d0 !== e.d || idx0 !== e.idx || wrap0 !== e.wrap || busy0 !== e.busy) begin
                bad++;
                $display("FAIL direct[%0d]: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                         i, d0, idx0, wrap0, busy0, e.d, e.idx, e.wrap, e.busy);
            end
        end
    endtask

    task automatic test_scan();
        logic [2:0] id;
        logic [7:0] dd;
        int         nw;
        nw = 0;
        ena = 1; mode = 1; a = 3'd6;
        for (int k = 0; k < 45; k++) begin
            id = 3'((6 + k / 5) % 8);
            dd = (k % 5 == 0) ? 8'h00 : (8'h01 << id);
            q.push_back(mk(dd, id, (k % 5 == 4) && (id == 3'd7), 1'b1));
            tick();
            if (k < 40 && wrap0 === 1'b1) nw++;
            e = q.pop_front(); total++;
            if (d0 !== e.d || idx0 !== e.idx || wrap0 !== e.wrap || busy0 !== e.busy) begin
                bad++;
                $display("FAIL scan[%0d]: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                         k, d0, idx0, wrap0, busy0, e.d, e.idx, e.wrap, e.busy);
            end
        end
        total++;
        if (nw !== 1) begin
            bad++;
            $display("FAIL scan_wrap_count: got %0d want 1", nw);
        end
    endtask

    task automatic test_reload();
        ena = 0;
        q.push_back(mk(8'h00, 3'd6, 1'b0, 1'b0));
        tick();
        e = q.pop_front(); total++;
        if (d0 !== e.d || idx0 !== e.idx || wrap0 !== e.wrap || busy0 !== e.busy) begin
            bad++;
            $display("FAIL reload_idle: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                     d0, idx0, wrap0, busy0, e.d, e.idx, e.wrap, e.busy);
        end
        ena = 1; mode = 1; a = 3'd2;
        for (int k = 0; k < 10; k++) begin
            ld = 0;
            if (k == 3) begin
                ld = 1; a = 3'd5;
            end else if (k > 3) begin
                a = 3'd0;
            end
            case (k)
                0:       q.push_back(mk(8'h00, 3'd2, 1'b0, 1'b1));
                1, 2:    q.push_back(mk(8'h04, 3'd2, 1'b0, 1'b1));
                3:       q.push_back(mk(8'h00, 3'd5, 1'b0, 1'b1));
                8:       q.push_back(mk(8'h00, 3'd6, 1'b0, 1'b1));
                9:       q.push_back(mk(8'h40, 3'd6, 1'b0, 1'b1));
                default: q.push_back(mk(8'h20, 3'd5, 1'b0, 1'b1));
            endcase
            tick();
            e = q.pop_front(); total++;
            if (d0 !== e.d || idx0 !== e.idx || wrap0 !== e.wrap || busy0 !== e.busy) begin
                bad++;
                $display("FAIL reload[%0d]: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                         k, d0, idx0, wrap0, busy0, e.d, e.idx, e.wrap, e.busy);
            end
        end
        ld = 0;
    endtask

    task automatic test_enable_drop();
        ena = 0;
        tick();
        ena = 1; mode = 1; a = 3'd4;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: q.push_back(mk(8'h00, 3'd4, 1'b0, 1'b1));
                1, 2: q.push_back(mk(8'h10, 3'd4, 1'b0, 1'b1));
                3, 4: begin
                    ena = 0;
                    q.push_back(mk(8'h00, 3'd4, 1'b0, 1'b0));
                end
                5: begin
                    ena = 1; mode = 1; a = 3'd1;
                    q.push_back(mk(8'h00, 3'd1, 1'b0, 1'b1));
                end
                default: q.push_back(mk(8'h02, 3'd1, 1'b0, 1'b1));
            endcase
            tick();
            e = q.pop_front(); total++;
            if (d0 !== e.d || idx0 !== e.idx || wrap0 !== e.wrap || busy0 !== e.busy) begin
                bad++;
                $display("FAIL enable_drop[%0d]: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                         k, d0, idx0, wrap0, busy0, e.d, e.idx, e.wrap, e.busy);
            end
        end
    endtask

    task automatic test_variant();
        logic [2:0] id;
        rst_n = 0;
        q.push_back(mk(8'hFF, 3'd0, 1'b0, 1'b0));
        tick();
        e = q.pop_front(); total++;
        if (d1 !== e.d || idx1 !== e.idx || wrap1 !== e.wrap || busy1 !== e.busy) begin
            bad++;
            $display("FAIL variant_reset: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                     d1, idx1, wrap1, busy1, e.d, e.idx, e.wrap, e.busy);
        end
        rst_n = 1; ena = 1; mode = 1; a = 3'd0;
        for (int k = 0; k < 35; k++) begin
            if (k < 34) begin
                id = 3'((k / 4) % 8);
                q.push_back(mk(~(8'h01 << id), id, (k % 4 == 3) && (id == 3'd7), 1'b1));
            end else begin
                mode = 0; a = 3'd3;
                q.push_back(mk(8'hF7, 3'd0, 1'b0, 1'b0));
            end
            tick();
            e = q.pop_front(); total++;
            if (d1 !== e.d || idx1 !== e.idx || wrap1 !== e.wrap || busy1 !== e.busy) begin
                bad++;
                $display("FAIL variant[%0d]: got d=%h idx=%0d wrap=%b busy=%b want d=%h idx=%0d wrap=%b busy=%b",
                         k, d1, idx1, wrap1, busy1, e.d, e.idx, e.wrap, e.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_reload();
        test_enable_drop();
        test_variant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
